// File: rtl/parity_pkg.sv
// ---------------------------------------------------------------------------
// parity_pkg
// Shared definitions for the parity framing blocks (receiver now, transmitter
// later):
//   rx_state_t  - receiver frame state (IDLE, DATA, PARITY, STOP)
//   DATA_W_DEF  - default number of data bits per frame
//   DATA_W_MAX  - widest data word the parity helper accepts
//   parity_of() - parity bit that a transmitter would append to 'data'
// ---------------------------------------------------------------------------
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam int DATA_W_DEF = 8;
  localparam int DATA_W_MAX = 16;

  // Parity bit to send with 'data' so that data plus parity bit has an even
  // (odd = 0) or odd (odd = 1) number of ones. Narrower words are passed
  // zero-extended, which leaves the result unchanged.
  function automatic logic parity_of(input logic [DATA_W_MAX-1:0] data,
                                     input logic                  odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/parity_calc.sv
// ---------------------------------------------------------------------------
// parity_calc
// Combinational parity generator: XOR-reduce of a data word with even/odd
// select. Gives the parity bit a transmitter would send for 'data'; the
// receiver compares it against the received parity bit.
// Parameters:
//   W          - data width (1..DATA_W_MAX)
//   ODD_PARITY - 0 = even parity, 1 = odd parity
// Ports:
//   data  in  [W-1:0]  word to protect
//   par   out 1        expected parity bit for 'data'
// ---------------------------------------------------------------------------
module parity_calc
  import parity_pkg::*;
#(
  parameter int W          = DATA_W_DEF,
  parameter int ODD_PARITY = 0
) (
  input  logic [W-1:0] data,
  output logic         par
);

  logic [DATA_W_MAX-1:0] data_ext;

  always_comb begin
    data_ext          = '0;
    data_ext[W-1:0]   = data;
  end

  assign par = parity_of(data_ext, ODD_PARITY != 0);

endmodule

// File: rtl/parity_frame_rx.sv
// ---------------------------------------------------------------------------
// parity_frame_rx
// Serial frame receiver with parity check. Frame format on ser_in:
//   start bit 0, DATA_W data bits LSB first, parity bit, stop bit 1.
// Bits are sampled only on cycles where bit_en is high (bit_en comes from the
// upstream bit-timing block; it may be held high for one bit per clock).
// A new start bit is accepted on the very next bit_en after a stop bit.
//
// Parameters:
//   DATA_W     - data bits per frame (2..16)
//   ODD_PARITY - 0 = even parity, 1 = odd parity
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset (aborts a frame in flight)
//   bit_en    in   sample strobe for ser_in
//   ser_in    in   serial line, idles at 1
//   data_out  out  [DATA_W-1:0] last received word
//   valid     out  data_out/pe/fe were just updated
//   pe        out  parity error of the last frame
//   fe        out  framing error of the last frame (stop bit sampled 0)
//   busy      out  a frame is in progress
//   data_ack  in   (PARITY_RX_HOLD_EN only) consumer has taken the word
//   ovr       out  (PARITY_RX_HOLD_EN only) one-cycle pulse: frame dropped
//
// Build option PARITY_RX_HOLD_EN: valid becomes a level held until data_ack;
// frames completing while valid is still high are dropped and flagged on ovr.
// Without it, valid is a single-cycle pulse and each frame overwrites the
// outputs.
// ---------------------------------------------------------------------------
module parity_frame_rx
  import parity_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ODD_PARITY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              ser_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              pe,
  output logic              fe,
`ifdef PARITY_RX_HOLD_EN
  input  logic              data_ack,
  output logic              ovr,
`endif
  output logic              busy
);

  localparam int              CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  rx_state_t         state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic              par_bit;
  logic              exp_par;
  logic              pe_calc;

  // Expected parity of the word currently in the shift register. It is
  // complete once the state machine reaches STOP.
  parity_calc #(
    .W          (DATA_W),
    .ODD_PARITY (ODD_PARITY)
  ) u_parity_calc (
    .data (shift_reg),
    .par  (exp_par)
  );

  assign pe_calc = exp_par ^ par_bit;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      data_out  <= '0;
      valid     <= 1'b0;
      pe        <= 1'b0;
      fe        <= 1'b0;
`ifdef PARITY_RX_HOLD_EN
      ovr       <= 1'b0;
`endif
    end else begin
`ifdef PARITY_RX_HOLD_EN
      ovr <= 1'b0;
      if (valid && data_ack) begin
        valid <= 1'b0;
      end
`else
      valid <= 1'b0;
`endif
      if (bit_en) begin
        case (state)
          IDLE: begin
            if (!ser_in) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            // LSB arrives first, so shift in at the MSB end.
            shift_reg <= {ser_in, shift_reg[DATA_W-1:1]};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            par_bit <= ser_in;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
`ifdef PARITY_RX_HOLD_EN
            // Unacknowledged word still on the outputs: keep it, drop this one.
            if (valid) begin
              ovr <= 1'b1;
            end else begin
              data_out <= shift_reg;
              pe       <= pe_calc;
              fe       <= ~ser_in;
              valid    <= 1'b1;
            end
`else
            data_out <= shift_reg;
            pe       <= pe_calc;
            fe       <= ~ser_in;
            valid    <= 1'b1;
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_parity_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_parity_frame_rx
// Drives an even-parity and an odd-parity receiver from the same serial
// stimulus and checks every delivered frame against a reference model that
// counts ones in data plus parity bit. Build option PARITY_RX_HOLD_EN adds
// the hold/overrun scenario.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_parity_frame_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bit_en;
  logic       ser_in;
  logic [7:0] data_out, data_out_o;
  logic       valid, pe, fe, busy;
  logic       valid_o, pe_o, fe_o, busy_o;
`ifdef PARITY_RX_HOLD_EN
  logic       data_ack;
  logic       ovr, ovr_o;
  bit         auto_ack;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  parity_frame_rx #(.DATA_W(8), .ODD_PARITY(0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bit_en   (bit_en),
    .ser_in   (ser_in),
    .data_out (data_out),
    .valid    (valid),
    .pe       (pe),
    .fe       (fe),
`ifdef PARITY_RX_HOLD_EN
    .data_ack (data_ack),
    .ovr      (ovr),
`endif
    .busy     (busy)
  );

  parity_frame_rx #(.DATA_W(8), .ODD_PARITY(1)) dut_odd (
    .clk      (clk),
    .rst_n    (rst_n),
    .bit_en   (bit_en),
    .ser_in   (ser_in),
    .data_out (data_out_o),
    .valid    (valid_o),
    .pe       (pe_o),
    .fe       (fe_o),
`ifdef PARITY_RX_HOLD_EN
    .data_ack (data_ack),
    .ovr      (ovr_o),
`endif
    .busy     (busy_o)
  );

  // ---------------- monitor: one record per delivered frame ----------------
  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic [7:0] data_o;
    logic       pe_o;
    logic       fe_o;
    logic       v_o;
    int         cyc;
  } rec_t;

  rec_t got_q[$];
  logic valid_prev = 1'b0;
  int   ovr_cnt    = 0;

  always @(negedge clk) begin
    rec_t r;
`ifdef PARITY_RX_HOLD_EN
    if (valid && !valid_prev) begin
`else
    if (valid) begin
`endif
      r.data   = data_out;
      r.pe     = pe;
      r.fe     = fe;
      r.data_o = data_out_o;
      r.pe_o   = pe_o;
      r.fe_o   = fe_o;
      r.v_o    = valid_o;
      r.cyc    = cyc;
      got_q.push_back(r);
    end
    valid_prev = valid;
`ifdef PARITY_RX_HOLD_EN
    if (ovr) ovr_cnt++;
`endif
  end

`ifdef PARITY_RX_HOLD_EN
  always @(negedge clk) if (auto_ack) data_ack = valid;
`endif

  // ---------------- reference model ----------------
  // Parity error: total ones in data plus parity bit must be even (even
  // parity) or odd (odd parity).
  function automatic logic model_pe(input logic [7:0] d, input logic p, input logic odd);
    int ones;
    ones = $countones(d) + int'(p);
    return odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  // ---------------- stimulus ----------------
  task automatic drive_bit(input logic b, input int gap);
    @(negedge clk);
    bit_en = 1'b1;
    ser_in = b;
    for (int i = 1; i < gap; i++) begin
      @(negedge clk);
      bit_en = 1'b0;
      ser_in = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int gap);
    drive_bit(1'b0, gap);
    for (int i = 0; i < 8; i++) drive_bit(d[i], gap);
    drive_bit(p, gap);
    drive_bit(s, gap);
  endtask

  // Waits (bounded) for the next delivered frame record.
  task automatic get_result(output bit ok, output rec_t r);
    ok = 1'b0;
    r  = '{default: 0};
    for (int i = 0; i < 8; i++) begin
      if (got_q.size() > 0) begin
        r  = got_q.pop_front();
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      bit_en = 1'b0;
      #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({data_out, valid, pe, fe, busy, data_out_o, valid_o, pe_o, fe_o, busy_o} !== '0) begin
      errors++;
      $display("FAIL reset_hold: got data=%h v=%b pe=%b fe=%b busy=%b, need all 0",
               data_out, valid, pe, fe, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({data_out, valid, pe, fe, busy} !== '0) begin
      errors++;
      $display("FAIL reset_release: got data=%h v=%b pe=%b fe=%b busy=%b, need all 0",
               data_out, valid, pe, fe, busy);
    end
  endtask

  task automatic test_known_frames();
    logic [7:0] td [3] = '{8'hEE, 8'hF8, 8'h55};
    logic       tp [3] = '{1'b0, 1'b0, 1'b0};
    logic       ts [3] = '{1'b1, 1'b1, 1'b0};
    int         tg [3] = '{4, 4, 1};
    logic       epe[3] = '{1'b0, 1'b1, 1'b0};
    logic       epo[3] = '{1'b1, 1'b0, 1'b1};
    logic       efe[3] = '{1'b0, 1'b0, 1'b1};
    bit   ok;
    rec_t r;
    for (int k = 0; k < 3; k++) begin
      send_frame(td[k], tp[k], ts[k], tg[k]);
      if (k == 2) begin
        @(negedge clk);
        bit_en = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b1) begin
          errors++;
          $display("FAIL known_busy_after_stop: got busy=%b valid=%b, need busy=0 valid=1",
                   busy, valid);
        end
      end
      get_result(ok, r);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL known_timeout[%0d]: no valid for frame %h", k, td[k]);
      end else begin
        $display("known frame %h: data=%h pe=%b fe=%b pe_odd=%b", td[k], r.data, r.pe, r.fe, r.pe_o);
        checks++;
        if (r.data !== td[k] || r.data_o !== td[k] || r.v_o !== 1'b1) begin
          errors++;
          $display("FAIL known_data[%0d]: got %h/%h v_odd=%b, need %h", k, r.data, r.data_o, r.v_o, td[k]);
        end
        checks++;
        if (r.pe !== epe[k] || r.pe_o !== epo[k]) begin
          errors++;
          $display("FAIL known_pe[%0d]: got even=%b odd=%b, need even=%b odd=%b",
                   k, r.pe, r.pe_o, epe[k], epo[k]);
        end
        checks++;
        if (r.fe !== efe[k] || r.fe_o !== efe[k]) begin
          errors++;
          $display("FAIL known_fe[%0d]: got %b/%b, need %b", k, r.fe, r.fe_o, efe[k]);
        end
      end
    end
  endtask

  task automatic test_random_frames();
    bit         ok;
    rec_t       r;
    logic [7:0] d;
    logic       p, s;
    int         gap;
    for (int n = 0; n < 40; n++) begin
      d   = 8'($urandom);
      p   = 1'($urandom_range(0, 1));
      s   = ($urandom_range(0, 3) != 0);
      gap = $urandom_range(1, 4);
      repeat ($urandom_range(0, 2)) drive_bit(1'b1, gap);
      send_frame(d, p, s, gap);
      get_result(ok, r);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rand_timeout[%0d]: no valid for frame %h", n, d);
      end else begin
        $display("rand frame %0d: sent %h p=%b s=%b gap=%0d -> data=%h pe=%b fe=%b pe_odd=%b",
                 n, d, p, s, gap, r.data, r.pe, r.fe, r.pe_o);
        checks++;
        if (r.data !== d || r.data_o !== d) begin
          errors++;
          $display("FAIL rand_data[%0d]: got %h/%h, need %h", n, r.data, r.data_o, d);
        end
        checks++;
        if (r.pe !== model_pe(d, p, 1'b0) || r.pe_o !== model_pe(d, p, 1'b1)) begin
          errors++;
          $display("FAIL rand_pe[%0d]: got even=%b odd=%b, need even=%b odd=%b", n, r.pe, r.pe_o,
                   model_pe(d, p, 1'b0), model_pe(d, p, 1'b1));
        end
        checks++;
        if (r.fe !== ~s || r.fe_o !== ~s) begin
          errors++;
          $display("FAIL rand_fe[%0d]: got %b/%b, need %b", n, r.fe, r.fe_o, ~s);
        end
      end
    end
    repeat (4) @(negedge clk);
    bit_en = 1'b0;
    #1;
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL rand_extra_valid: got %0d extra records, need 0", got_q.size());
      got_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    bit   ok1, ok2;
    rec_t r1, r2;
    send_frame(8'hA5, 1'b0, 1'b1, 1);
    send_frame(8'h3C, 1'b0, 1'b1, 1);
    get_result(ok1, r1);
    get_result(ok2, r2);
    checks++;
    if (!ok1 || !ok2) begin
      errors++;
      $display("FAIL b2b_timeout: got %0d frames, need 2", int'(ok1) + int'(ok2));
    end else begin
      $display("b2b frames: %h at cycle %0d, %h at cycle %0d", r1.data, r1.cyc, r2.data, r2.cyc);
      checks++;
      if (r1.data !== 8'hA5 || r2.data !== 8'h3C || r1.pe !== 1'b0 || r2.pe !== 1'b0) begin
        errors++;
        $display("FAIL b2b_data: got %h pe=%b, %h pe=%b, need a5 pe=0, 3c pe=0",
                 r1.data, r1.pe, r2.data, r2.pe);
      end
      checks++;
      if (r2.cyc - r1.cyc != 11) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d clocks, need 11", r2.cyc - r1.cyc);
      end
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_extra_valid: got %0d extra records, need 0", got_q.size());
      got_q.delete();
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d = 8'h81;
    bit         ok;
    rec_t       r;
    drive_bit(1'b0, 2);
    for (int i = 0; i < 4; i++) drive_bit(d[i], 2);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_busy_before: got %b, need 1", busy);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({data_out, valid, pe, fe, busy, data_out_o, busy_o} !== '0) begin
      errors++;
      $display("FAIL midreset_async: got data=%h v=%b pe=%b fe=%b busy=%b, need all 0",
               data_out, valid, pe, fe, busy);
    end
    bit_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (got_q.size() != 0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_valid: got %0d records valid=%b, need 0", got_q.size(), valid);
      got_q.delete();
    end
    send_frame(d, 1'b0, 1'b1, 3);
    get_result(ok, r);
    checks++;
    if (!ok || r.data !== 8'h81 || r.pe !== 1'b0 || r.pe_o !== 1'b1 || r.fe !== 1'b0) begin
      errors++;
      $display("FAIL midreset_next_frame: got ok=%b data=%h pe=%b pe_odd=%b fe=%b, need 81 0 1 0",
               ok, r.data, r.pe, r.pe_o, r.fe);
    end else begin
      $display("post-reset frame: data=%h pe=%b fe=%b", r.data, r.pe, r.fe);
    end
  endtask

`ifdef PARITY_RX_HOLD_EN
  task automatic test_hold();
    bit   ok;
    rec_t r;
    int   ovr_base;
    auto_ack = 1'b0;
    data_ack = 1'b0;
    repeat (3) @(negedge clk);
    send_frame(8'h12, 1'b0, 1'b1, 2);
    get_result(ok, r);
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (!ok || valid !== 1'b1 || data_out !== 8'h12) begin
      errors++;
      $display("FAIL hold_level: got ok=%b valid=%b data=%h, need 1 1 12", ok, valid, data_out);
    end
    ovr_base = ovr_cnt;
    send_frame(8'h34, 1'b1, 1'b1, 2);
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (valid !== 1'b1 || data_out !== 8'h12 || ovr_cnt - ovr_base != 1 || got_q.size() != 0) begin
      errors++;
      $display("FAIL hold_overrun: got valid=%b data=%h ovr_pulses=%0d, need 1 12 1",
               valid, data_out, ovr_cnt - ovr_base);
    end else begin
      $display("hold overrun: data kept %h, ovr pulses %0d", data_out, ovr_cnt - ovr_base);
    end
    @(negedge clk);
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    #1;
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_ack: got valid=%b, need 0", valid);
    end
    got_q.delete();
    auto_ack = 1'b1;
  endtask
`endif

  initial begin
    rst_n  = 1'b0;
    bit_en = 1'b0;
    ser_in = 1'b1;
`ifdef PARITY_RX_HOLD_EN
    data_ack = 1'b0;
    auto_ack = 1'b1;
`endif
    test_reset();
    test_known_frames();
    test_random_frames();
    test_back_to_back();
    test_reset_midframe();
`ifdef PARITY_RX_HOLD_EN
    test_hold();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/parity_frame_rx.md
Name: parity_frame_rx

Overview:
- Receive-side counterpart of the team's 8-bit parity generator.
- Deserialises a framed serial stream: start bit 0, DATA_W data bits LSB-first, one parity bit, stop bit 1.
- Recomputes parity over the received data and checks it against the received parity bit.
- Presents parallel data with parity-error and framing-error flags to downstream logic. Sits at the serial-link input, after the bit-timing block that generates bit_en.

Parameters:
- DATA_W, 8, number of data bits per frame (2..16).
- ODD_PARITY, 0, 0 = even parity (data ^ parity bit has an even count of ones), 1 = odd parity.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- bit_en  input  1  one-cycle strobe marking the sample point of each serial bit.
- ser_in  input  1  serial line; idle level 1.
- data_out  output  DATA_W  last received data word.
- valid  output  1  one-cycle pulse: data_out, pe and fe are updated.
- pe  output  1  parity error of the last frame.
- fe  output  1  framing error of the last frame (stop bit sampled 0).
- busy  output  1  high while a frame is in progress (state != IDLE).
- data_ack  input  1  present only with PARITY_RX_HOLD_EN.
- ovr  output  1  present only with PARITY_RX_HOLD_EN.

Behaviour:
- Reset values: data_out = 0, valid = 0, pe = 0, fe = 0, busy = 0, state = IDLE, bit counter = 0, shift register = 0. Asserting rst_n mid-frame aborts the frame; no valid pulse is produced.
- All sampling happens only on cycles with bit_en = 1. ser_in is ignored on other cycles.
- State IDLE: bit_en & ser_in = 0 -> DATA, counter = 0. bit_en & ser_in = 1 -> stay in IDLE.
- State DATA: on each bit_en, shift ser_in into the shift register MSB end (LSB-first framing), counter += 1. After the DATA_W-th bit -> PARITY.
- State PARITY: on bit_en, latch the parity bit -> STOP.
- State STOP: on bit_en, update registered outputs at the same clock edge and return to IDLE:
  - data_out = shift register.
  - pe = (^shift register) ^ parity bit ^ ODD_PARITY.
  - fe = ~ser_in.
  - valid = 1 for exactly one cycle.
- Latency: valid is high in the cycle after the clk edge on which the stop-bit bit_en was sampled.
- pe and fe hold their values until the next valid. A frame with fe = 1 still delivers data_out and pe.
- A start bit is accepted in the bit_en immediately after STOP (back-to-back frames). No idle bit is required.
- Counter width is $clog2(DATA_W+1). The counter saturates at no value and is cleared on each start bit.
- bit_en held high continuously is legal: one bit per clock.

Optional Feature:
- Macro: PARITY_RX_HOLD_EN.
- Defined:
  - valid becomes a level, held until data_ack = 1 (sampled on clk). valid and data_ack both high -> valid drops the next cycle.
  - If a new frame completes while valid is still high, data_out, pe and fe are not overwritten (the new frame is dropped). ovr pulses high for 1 cycle and valid stays high.
  - data_ack with valid = 0 has no effect.
- Undefined:
  - valid is a 1-cycle pulse and every frame overwrites the outputs.
  - data_ack and ovr ports do not exist.

Decomposition:
- Package parity_pkg holds:
  - state enum rx_state_t {IDLE, DATA, PARITY, STOP} (2 bits).
  - localparam DATA_W_DEF = 8.
  - function parity_of(data, odd), shared with the transmit side.
- One sub-module, parity_calc: combinational XOR-reduce with the odd/even select, instantiated once for the pe calculation. Reused by the future transmitter.

Test Plan:
- Even parity, frame 0 / 0xEE (LSB first) / parity 0 / stop 1 with bit_en every 4th cycle -> valid pulse, data_out = 8'hEE, pe = 0, fe = 0.
- Frame 0xF8 with parity bit 0 (correct is 1) -> data_out = 8'hF8, pe = 1, fe = 0. With ODD_PARITY = 1, the same frame gives pe = 0.
- Frame 0x55 with parity 0 and stop bit 0 -> data_out = 8'h55, pe = 0, fe = 1. busy returns to 0 the cycle after the stop-bit bit_en.
- Two back-to-back frames 0xA5 then 0x3C, bit_en held continuously high -> two valid pulses 11 clocks apart with the correct data, no frame lost.
- rst_n pulsed low during data bit 4 of frame 0x81 -> all outputs 0 immediately (asynchronous), no valid. The next full frame 0x81 decodes correctly.
- With PARITY_RX_HOLD_EN: receive 0x12 with no ack, then 0x34 -> valid stays high, data_out = 8'h12, ovr pulses once. After data_ack, valid drops the next cycle.
